// File: rtl/imgmem_fill_ctrl.sv
// Image-RAM port A arbiter and rectangle-fill sequencer (processor has strict priority).
// Optional abort input is enabled by defining IMGFILL_ABORT_EN.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a fill command, cmd_ready high
// SETUP | clip captured rectangle to the frame, load row base
// FILL  | one pixel per non-stalled cycle, row-major
// DONE  | one-cycle completion pulse
module imgmem_fill_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
`ifdef IMGFILL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              proc_req,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int         BW     = ADDR_W + 1;
  localparam logic [10:0] LP_H  = 11'(H_RES);
  localparam logic [9:0]  LP_V  = 10'(V_RES);

  logic [1:0]        r_state;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic [9:0]        r_w;
  logic [8:0]        r_h;
  logic [DATA_W-1:0] r_color;
  logic [9:0]        r_w_eff;
  logic [8:0]        r_h_eff;
  logic [9:0]        r_col;
  logic [8:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;

  logic              w_accept;
  logic              w_stall;
  logic              w_abort;
  logic              w_empty;
  logic [10:0]       w_x_room;
  logic [9:0]        w_y_room;
  logic [9:0]        w_w_eff;
  logic [8:0]        w_h_eff;
  logic [ADDR_W-1:0] w_cur_addr;
  logic              w_col_last;
  logic              w_row_last;

  assign busy      = (r_state == ST_SETUP) || (r_state == ST_FILL);
  assign done      = (r_state == ST_DONE);
  assign cmd_ready = reset_n && (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_stall   = proc_req;

`ifdef IMGFILL_ABORT_EN
  assign w_abort = abort && busy;
`else
  assign w_abort = 1'b0;
`endif

  // Clipping works on the captured command; room values only matter when not empty.
  assign w_empty  = ({1'b0, r_x} >= LP_H) || ({1'b0, r_y} >= LP_V) ||
                    (r_w == 10'd0) || (r_h == 9'd0);
  assign w_x_room = LP_H - {1'b0, r_x};
  assign w_y_room = LP_V - {1'b0, r_y};
  assign w_w_eff  = ({1'b0, r_w} < w_x_room) ? r_w : w_x_room[9:0];
  assign w_h_eff  = ({1'b0, r_h} < w_y_room) ? r_h : w_y_room[8:0];

  assign w_cur_addr = r_row_base + ADDR_W'(r_col);
  assign w_col_last = (r_col == r_w_eff - 10'd1);
  assign w_row_last = (r_row == r_h_eff - 9'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_w_eff    <= '0;
      r_h_eff    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (!w_stall) begin
            if (w_empty) begin
              r_state <= ST_DONE;
            end else begin
              r_w_eff    <= w_w_eff;
              r_h_eff    <= w_h_eff;
              r_col      <= '0;
              r_row      <= '0;
              // Product is formed one bit wider than the address bus; in-frame values fit.
              r_row_base <= ADDR_W'(BW'(r_y) * BW'(H_RES) + BW'(r_x));
              r_state    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (!w_stall) begin
            if (w_col_last && w_row_last) begin
              r_state <= ST_DONE;
            end else if (w_col_last) begin
              r_col      <= '0;
              r_row      <= r_row + 9'd1;
              r_row_base <= r_row_base + ADDR_W'(H_RES);
            end else begin
              r_col <= r_col + 10'd1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Port A mux: reset forces quiet outputs, then processor, then the fill engine.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (!reset_n) begin
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
    end else if (proc_req) begin
      mem_addr = proc_addr;
      mem_data = proc_data;
      mem_wren = proc_wren;
    end else if (r_state == ST_FILL) begin
      mem_addr = w_cur_addr;
      mem_data = r_color;
      mem_wren = 1'b1;
    end else begin
      mem_addr = proc_addr;
      mem_data = proc_data;
      mem_wren = 1'b0;
    end
  end

endmodule

// File: tb/tb_imgmem_fill_ctrl.sv
// Directed bench for imgmem_fill_ctrl; abort steps compile in when IMGFILL_ABORT_EN is defined.
module tb_imgmem_fill_ctrl;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        proc_req;
  logic [18:0] proc_addr;
  logic [7:0]  proc_data;
  logic        proc_wren;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        abort_drv;

  always #5 clock = ~clock;

  imgmem_fill_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
`ifdef IMGFILL_ABORT_EN
    .abort     (abort_drv),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .proc_req  (proc_req),
    .proc_addr (proc_addr),
    .proc_data (proc_data),
    .proc_wren (proc_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wren  (mem_wren),
    .busy      (busy),
    .done      (done)
  );

  int total = 0;
  int bad   = 0;
  int wa[$];
  int wd[$];
  int ea[$];
  int ed[$];
  int done_at;
  int done_cnt;
  int wr_cnt;
  logic ready_after;
  logic busy1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one command, then logs every port-A write and the done pulse cycle by cycle.
  // Cycle n=1 is the cycle right after the accept edge.
  task automatic run_cmd(input string nm, input logic [9:0] x, input logic [8:0] y,
                         input logic [9:0] w, input logic [8:0] h, input logic [7:0] c,
                         input int st_s, input int st_n, input int ab_at, input int max_n);
    wa.delete();
    wd.delete();
    done_at = 0;
    done_cnt = 0;
    ready_after = 1'b0;
    busy1 = 1'b0;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    #1;
    check({nm, "_ready_before"}, 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd1; cmd_h = 9'd1; cmd_color = 8'h00;
    for (int n = 1; n <= max_n; n++) begin
      proc_req  = (n >= st_s) && (n < st_s + st_n);
      proc_wren = proc_req;
      proc_addr = 19'd5;
      proc_data = 8'h11;
      abort_drv = (n == ab_at);
      @(negedge clock);
      if (n == 1) busy1 = busy;
      if (mem_wren) begin
        wa.push_back(int'(mem_addr));
        wd.push_back(int'(mem_data));
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (done_at != 0 && n == done_at + 1) begin
        ready_after = cmd_ready;
        break;
      end
      @(posedge clock); #1;
    end
    proc_req = 1'b0; proc_wren = 1'b0; abort_drv = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_writes(input string nm);
    check({nm, "_wr_count"}, 32'(wa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", nm, i), 32'(wa[i]), 32'(ea[i]));
      check($sformatf("%s_data%0d", nm, i), 32'(wd[i]), 32'(ed[i]));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    proc_req = 1'b1; proc_wren = 1'b1; proc_addr = 19'd7; proc_data = 8'h22;
    abort_drv = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_wren", 32'(mem_wren), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    reset_n = 1'b1;
    proc_req = 1'b0;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_mem_addr", 32'(mem_addr), 32'd7);
    check("idle_mem_wren", 32'(mem_wren), 32'd0);
    proc_wren = 1'b0;
    @(posedge clock); #1;

    // 3x2 fill at (10,20)
    run_cmd("t1", 10'd10, 9'd20, 10'd3, 9'd2, 8'h5A, 0, 0, 0, 30);
    ea = '{12810, 12811, 12812, 13450, 13451, 13452};
    ed = '{90, 90, 90, 90, 90, 90};
    check_writes("t1");
    check("t1_done_at", 32'(done_at), 32'd8);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy1", 32'(busy1), 32'd1);
    check("t1_ready_after", 32'(ready_after), 32'd1);

    // bottom-right corner, clipped to 2x1
    run_cmd("t2", 10'd638, 9'd479, 10'd5, 9'd4, 8'h3C, 0, 0, 0, 30);
    ea = '{307198, 307199};
    ed = '{60, 60};
    check_writes("t2");
    check("t2_done_at", 32'(done_at), 32'd4);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // empty rectangles
    run_cmd("t3a", 10'd10, 9'd20, 10'd0, 9'd2, 8'hFF, 0, 0, 0, 20);
    ea.delete(); ed.delete();
    check_writes("t3a");
    check("t3a_done_at", 32'(done_at), 32'd2);
    run_cmd("t3b", 10'd700, 9'd0, 10'd5, 9'd1, 8'hFF, 0, 0, 0, 20);
    check_writes("t3b");
    check("t3b_done_at", 32'(done_at), 32'd2);
    check("t3b_ready_after", 32'(ready_after), 32'd1);
    run_cmd("t3c", 10'd0, 9'd480, 10'd5, 9'd1, 8'hFF, 0, 0, 0, 20);
    check_writes("t3c");
    check("t3c_done_at", 32'(done_at), 32'd2);

    // 4x1 with processor owning port A in cycles 3 and 4
    run_cmd("t4", 10'd0, 9'd1, 10'd4, 9'd1, 8'hC3, 3, 2, 0, 30);
    ea = '{640, 5, 5, 641, 642, 643};
    ed = '{195, 17, 17, 195, 195, 195};
    check_writes("t4");
    check("t4_done_at", 32'(done_at), 32'd8);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // reset in the middle of a fill
    cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd8; cmd_h = 9'd1; cmd_color = 8'h77;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    @(negedge clock);
    check("t5_wren_before", 32'(mem_wren), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_wren_in_reset", 32'(mem_wren), 32'd0);
    check("t5_busy_in_reset", 32'(busy), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_ready_after", 32'(cmd_ready), 32'd1);
    done_cnt = 0;
    wr_cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) done_cnt++;
      if (mem_wren) wr_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_no_writes", 32'(wr_cnt), 32'd0);
    @(posedge clock); #1;

`ifdef IMGFILL_ABORT_EN
    // abort on the third pixel of the second row of an 8x4 fill
    run_cmd("t6", 10'd0, 9'd0, 10'd8, 9'd4, 8'hE1, 0, 0, 12, 40);
    ea = '{0, 1, 2, 3, 4, 5, 6, 7, 640, 641, 642};
    ed = '{225, 225, 225, 225, 225, 225, 225, 225, 225, 225, 225};
    check_writes("t6");
    check("t6_no_done", 32'(done_cnt), 32'd0);
    check("t6_busy_after", 32'(busy), 32'd0);
    run_cmd("t6b", 10'd3, 9'd3, 10'd1, 9'd1, 8'h01, 0, 0, 0, 20);
    ea = '{1923};
    ed = '{1};
    check_writes("t6b");
    check("t6b_done_at", 32'(done_at), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
